c_requant_drain: RTL

C_REQUANT_DRAIN -- requirements
Module: c_requant_drain

---
 rtl/c_requant_drain.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/c_requant_drain.sv
// c_requant_drain: drains the C matrix from its global buffer, requantizes
// every int32 lane to int8 and writes packed results to the output buffer.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid            start pulse; M, N, mult, shift, zp sampled with it
//   M, N                matrix rows / columns
//   mult, shift, zp     signed multiplier, rounding right-shift, signed zero point
//   busy, done          drain in progress / one-cycle completion pulse
//   C_rd_index          C buffer read index (data returns one cycle later)
//   C_data_out          C entry, four signed int32 lanes
//   O_wr_en, O_index    output buffer write strobe and index
//   O_data_in           four packed int8 results, byte i = lane i
module c_requant_drain #(
  parameter int unsigned IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       M,
  input  logic [7:0]       N,
  input  logic [15:0]      mult,
  input  logic [4:0]       shift,
  input  logic [7:0]       zp,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] C_rd_index,
  input  logic [127:0]     C_data_out,
  output logic             O_wr_en,
  output logic [IDX_W-1:0] O_index,
  output logic [31:0]      O_data_in
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e state_q;

  // Latched configuration
  logic [7:0]  m_q, n_q;
  logic [15:0] mult_q;
  logic [4:0]  shift_q;
  logic [7:0]  zp_q;

  // Issue counters: row r and column tile t of the entry at C_rd_index
  logic [7:0] r_q;
  logic [6:0] t_q;

  // Stage 0: index issued, C data arrives during this stage
  logic             v0_q;
  logic [IDX_W-1:0] e0_q;
  logic [6:0]       t0_q;
  // Stage 1: registered products
  logic             v1_q;
  logic [IDX_W-1:0] e1_q;
  logic [6:0]       t1_q;
  logic [47:0]      p_q [4];

  logic [6:0]  tiles;
  logic        last_row, last_tile;
  logic [47:0] prod [4];
  logic [31:0] packed_res;

  always_comb begin
    tiles     = 7'((9'(n_q) + 9'd3) >> 2);
    last_row  = (r_q == m_q - 8'd1);
    last_tile = (t_q == tiles - 7'd1);
  end

  // Sign-extend both operands to 48 bits; the low 48 bits of the unsigned
  // product are the exact signed product.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      prod[i] = {{16{C_data_out[32*i+31]}}, C_data_out[32*i +: 32]} *
                {{32{mult_q[15]}}, mult_q};
    end
  end

  // Stage 2: round-half-up shift, add zero point, saturate, zero padding lanes.
  // 49 bits keep p + 2^(shift-1) and the zero-point add free of overflow.
  logic signed [48:0] rnd, sum, res, v;
  logic [7:0]         sat;
  logic [8:0]         col;

  always_comb begin
    packed_res = '0;
    rnd        = '0;
    sum        = '0;
    res        = '0;
    v          = '0;
    sat        = '0;
    col        = '0;
    for (int i = 0; i < 4; i++) begin
      rnd = '0;
      if (shift_q != 5'd0) rnd[shift_q - 5'd1] = 1'b1;
      sum = $signed({p_q[i][47], p_q[i]}) + rnd;
      res = sum >>> shift_q;
      v   = res + $signed({{41{zp_q[7]}}, zp_q});
      if (v > 49'sd127) begin
        sat = 8'h7f;
      end else if (v < -49'sd128) begin
        sat = 8'h80;
      end else begin
        sat = v[7:0];
      end
      col = {t1_q, 2'b00} + 9'(i);
      if (col < {1'b0, n_q}) packed_res[8*i +: 8] = sat;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      C_rd_index <= '0;
      r_q        <= '0;
      t_q        <= '0;
      m_q        <= '0;
      n_q        <= '0;
      mult_q     <= '0;
      shift_q    <= '0;
      zp_q       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            m_q        <= M;
            n_q        <= N;
            mult_q     <= mult;
            shift_q    <= shift;
            zp_q       <= zp;
            C_rd_index <= '0;
            r_q        <= '0;
            t_q        <= '0;
            if (M == 8'd0 || N == 8'd0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StRun;
              busy    <= 1'b1;
            end
          end
        end
        StRun: begin
          if (last_row && last_tile) begin
            state_q <= StFlush;
          end else begin
            C_rd_index <= C_rd_index + 1'b1;
            if (last_row) begin
              r_q <= '0;
              t_q <= t_q + 7'd1;
            end else begin
              r_q <= r_q + 8'd1;
            end
          end
        end
        StFlush: begin
          // Stages 0 and 1 empty: the final write is being registered now
          if (!v0_q && !v1_q) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Data pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q      <= 1'b0;
      e0_q      <= '0;
      t0_q      <= '0;
      v1_q      <= 1'b0;
      e1_q      <= '0;
      t1_q      <= '0;
      O_wr_en   <= 1'b0;
      O_index   <= '0;
      O_data_in <= '0;
      for (int i = 0; i < 4; i++) p_q[i] <= '0;
    end else begin
      v0_q <= (state_q == StRun);
      e0_q <= C_rd_index;
      t0_q <= t_q;
      v1_q <= v0_q;
      e1_q <= e0_q;
      t1_q <= t0_q;
      for (int i = 0; i < 4; i++) p_q[i] <= prod[i];
      O_wr_en <= v1_q;
      if (v1_q) begin
        O_index   <= e1_q;
        O_data_in <= packed_res;
      end
    end
  end

endmodule
